// File: rtl/regfile_dma_master.sv
// Register-file DMA master.
// Runs one COPY, FILL or ADDK command at a time over a 16-entry register file.
// Indices wrap modulo 16. Each word is written before the next word is read,
// so overlapping ranges copy forward.
module regfile_dma_master #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_src,
    input  logic [3:0]        cmd_dst,
    input  logic [4:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rf_re,
    output logic [3:0]        rf_rAddr,
    input  logic [DATA_W-1:0] rf_rData,
    output logic              rf_we,
    output logic [3:0]        rf_wAddr,
    output logic [DATA_W-1:0] rf_wData,
    output logic              busy,
    output logic              done,
    output logic [4:0]        xfer_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    localparam logic [1:0] OP_COPY = 2'b00;
    localparam logic [1:0] OP_FILL = 2'b01;
    localparam logic [1:0] OP_ADDK = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t            state;
    state_t            stateNxt;
    logic [1:0]        op_q;
    logic [3:0]        src_ptr;
    logic [3:0]        dst_ptr;
    logic [4:0]        len_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] capVal;
    logic              accept;
    logic              lastWord;

    assign accept   = cmd_valid && (state == IDLE);
    assign lastWord = ((xfer_cnt + 5'd1) == len_q);

    // COPY passes the read word through unchanged; ADDK adds the addend, dropping the carry.
    assign capVal = (op_q == OP_ADDK) ? (rf_rData + data_q) : rf_rData;

    // All handshake and strobe outputs are decoded from the state alone.
    // Reset therefore clears them the instant it is asserted.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign rf_re     = (state == RD);
    assign rf_we     = (state == WR);

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Next-state sequencing.
    // Empty and reserved commands go straight to DONE. FILL skips the read half.
    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == 5'd0 || cmd_op == OP_RSVD) begin
                        stateNxt = DONE;
                    end else if (cmd_op == OP_FILL) begin
                        stateNxt = WR;
                    end else begin
                        stateNxt = RD;
                    end
                end
            end
            RD:  stateNxt = CAP;
            CAP: stateNxt = WR;
            WR: begin
                if (lastWord) begin
                    stateNxt = DONE;
                end else if (op_q == OP_FILL) begin
                    stateNxt = WR;
                end else begin
                    stateNxt = RD;
                end
            end
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Command latch, pointers, word counter and the address/data output registers.
    // rf_wData doubles as the capture buffer. The address registers load only on
    // entry to RD or WR, so they hold their last value everywhere else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_COPY;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            len_q    <= '0;
            data_q   <= '0;
            xfer_cnt <= '0;
            rf_rAddr <= '0;
            rf_wAddr <= '0;
            rf_wData <= '0;
        end else begin
            if (accept) begin
                op_q     <= cmd_op;
                src_ptr  <= cmd_src;
                dst_ptr  <= cmd_dst;
                len_q    <= cmd_len;
                data_q   <= cmd_data;
                xfer_cnt <= '0;
            end
            if (state == WR) begin
                xfer_cnt <= xfer_cnt + 5'd1;
                src_ptr  <= src_ptr + 4'd1;
                dst_ptr  <= dst_ptr + 4'd1;
            end
            if (state == CAP) begin
                rf_wData <= capVal;
            end
            if (stateNxt == RD) begin
                rf_rAddr <= (state == IDLE) ? cmd_src : (src_ptr + 4'd1);
            end
            if (stateNxt == WR) begin
                if (state == IDLE) begin
                    rf_wAddr <= cmd_dst;
                    rf_wData <= cmd_data;
                end else if (state == WR) begin
                    rf_wAddr <= dst_ptr + 4'd1;
                    rf_wData <= data_q;
                end else begin
                    rf_wAddr <= dst_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_dma_master.sv
// Testbench for regfile_dma_master.
// A behavioural register file is attached to the DUT. Expected contents come
// from a simple per-word loop over each command. Done timing follows the
// command type and length.
module tb_regfile_dma_master;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [3:0]        cmd_src = '0;
    logic [3:0]        cmd_dst = '0;
    logic [4:0]        cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rf_re;
    logic [3:0]        rf_rAddr;
    logic [DATA_W-1:0] rf_rData;
    logic              rf_we;
    logic [3:0]        rf_wAddr;
    logic [DATA_W-1:0] rf_wData;
    logic              busy;
    logic              done;
    logic [4:0]        xfer_cnt;

    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] expMem [16];
    logic [DATA_W-1:0] loadImg [16];
    logic              tbLoad = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [4:0]  len;
        logic [31:0] data;
        int          expCycle;
        logic [3:0]  chkAddr;
        logic [31:0] chkVal;
    } vec_t;

    vec_t vecs [6];

    regfile_dma_master #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rf_re     (rf_re),
        .rf_rAddr  (rf_rAddr),
        .rf_rData  (rf_rData),
        .rf_we     (rf_we),
        .rf_wAddr  (rf_wAddr),
        .rf_wData  (rf_wData),
        .busy      (busy),
        .done      (done),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Register file: read data is registered, writes land on the edge.
    // A bulk load port lets the bench seed the contents.
    always @(posedge clk) begin
        if (tbLoad) begin
            for (int i = 0; i < 16; i++) mem[i] <= loadImg[i];
        end else if (rf_we) begin
            mem[rf_wAddr] <= rf_wData;
        end
        if (rf_re) rf_rData <= mem[rf_rAddr];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic loadMem();
        @(negedge clk);
        tbLoad = 1'b1;
        for (int i = 0; i < 16; i++) expMem[i] = loadImg[i];
        @(negedge clk);
        tbLoad = 1'b0;
    endtask

    task automatic checkMem(input string name);
        int firstBad;
        firstBad = -1;
        for (int i = 15; i >= 0; i--) if (mem[i] !== expMem[i]) firstBad = i;
        if (firstBad < 0) checkOutput(name, 64'(mem[0]), 64'(expMem[0]));
        else checkOutput(name, 64'(mem[firstBad]), 64'(expMem[firstBad]));
    endtask

    // Issue one command and watch it to completion.
    // While the DUT is busy, random junk is driven on the command inputs.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                                 input logic [4:0] len, input logic [31:0] data, input int expCycle);
        int doneAt, reads, writes, both, expRw, expReads;
        logic busyAtDone;
        logic [4:0] cntAtDone;
        logic [3:0] rA, wA;
        logic [3:0] s, d;
        logic [63:0] w;
        doneAt = 0; reads = 0; writes = 0; both = 0;
        busyAtDone = 1'b0; cntAtDone = '0; rA = '0; wA = '0;

        // Reference model: walk the words in order, so overlapping ranges copy forward.
        expRw = (op == 2'b11) ? 0 : int'(len);
        expReads = (op == 2'b00 || op == 2'b10) ? expRw : 0;
        for (int i = 0; i < expRw; i++) begin
            s = 4'((int'(src) + i) % 16);
            d = 4'((int'(dst) + i) % 16);
            if (op == 2'b01) expMem[d] = data;
            else if (op == 2'b10) begin
                w = 64'(expMem[s]) + 64'(data);
                expMem[d] = w[31:0];
            end else expMem[d] = expMem[s];
        end

        @(negedge clk);
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_data = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 400 && doneAt == 0; k++) begin
            @(negedge clk);
            if (rf_re) reads++;
            if (rf_we) writes++;
            if (rf_re && rf_we) both++;
            if (done) begin
                doneAt = k;
                busyAtDone = busy;
                cntAtDone = xfer_cnt;
                rA = rf_rAddr;
                wA = rf_wAddr;
                cmd_valid = 1'b0;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = 2'($urandom_range(0, 3));
                cmd_src = 4'($urandom_range(0, 15));
                cmd_dst = 4'($urandom_range(0, 15));
                cmd_len = 5'($urandom_range(0, 31));
                cmd_data = $urandom;
            end
        end
        cmd_valid = 1'b0;
        checkOutput("done_cycle", 64'(doneAt), 64'(expCycle));
        checkOutput("busy_at_done", 64'(busyAtDone), 64'd1);
        checkOutput("xfer_cnt_at_done", 64'(cntAtDone), 64'(expRw));
        checkOutput("read_pulses", 64'(reads), 64'(expReads));
        checkOutput("write_pulses", 64'(writes), 64'(expRw));
        checkOutput("re_we_overlap", 64'(both), 64'd0);
        if (expRw > 0) checkOutput("wAddr_hold", 64'(wA), 64'((int'(dst) + expRw - 1) % 16));
        if (expReads > 0) checkOutput("rAddr_hold", 64'(rA), 64'((int'(src) + expRw - 1) % 16));
        @(negedge clk);
        checkOutput("done_one_cycle", {62'd0, done, busy}, 64'd0);
        checkMem("mem_contents");
    endtask

    function automatic int modelCycle(input logic [1:0] op, input logic [4:0] len);
        if (op == 2'b11 || len == 5'd0) return 1;
        if (op == 2'b01) return int'(len) + 1;
        return 3 * int'(len) + 1;
    endfunction

    initial begin
        int wr;
        logic [1:0] rop;
        logic [4:0] rlen;

        vecs[0] = '{op: 2'b00, src: 4'd2,  dst: 4'd8,  len: 5'd3, data: 32'h0,        expCycle: 10, chkAddr: 4'd10, chkVal: 32'h33};
        vecs[1] = '{op: 2'b10, src: 4'd5,  dst: 4'd5,  len: 5'd1, data: 32'hFFFFFFFF, expCycle: 4,  chkAddr: 4'd5,  chkVal: 32'h0};
        vecs[2] = '{op: 2'b00, src: 4'd0,  dst: 4'd1,  len: 5'd3, data: 32'h0,        expCycle: 10, chkAddr: 4'd3,  chkVal: 32'hA};
        vecs[3] = '{op: 2'b01, src: 4'd0,  dst: 4'd14, len: 5'd4, data: 32'hDEADBEEF, expCycle: 5,  chkAddr: 4'd1,  chkVal: 32'hDEADBEEF};
        vecs[4] = '{op: 2'b00, src: 4'd3,  dst: 4'd7,  len: 5'd0, data: 32'h0,        expCycle: 1,  chkAddr: 4'd7,  chkVal: 32'h107};
        vecs[5] = '{op: 2'b11, src: 4'd0,  dst: 4'd12, len: 5'd5, data: 32'h5,        expCycle: 1,  chkAddr: 4'd12, chkVal: 32'h10C};

        for (int i = 0; i < 16; i++) loadImg[i] = 32'h100 + 32'(i);
        loadImg[0] = 32'hA; loadImg[1] = 32'hB;
        loadImg[2] = 32'h11; loadImg[3] = 32'h22; loadImg[4] = 32'h33; loadImg[5] = 32'h1;
        loadMem();

        // Reset state, then release.
        @(negedge clk);
        checkOutput("reset_outputs", {rf_re, rf_we, done, busy, xfer_cnt, rf_rAddr, rf_wAddr, rf_wData}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Directed vectors.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].data, vecs[v].expCycle);
            checkOutput($sformatf("vec%0d_word", v), 64'(mem[vecs[v].chkAddr]), 64'(vecs[v].chkVal));
        end

        // Random commands against the model.
        for (int r = 0; r < 30; r++) begin
            rop = 2'($urandom_range(0, 3));
            rlen = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus(rop, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rlen, $urandom, modelCycle(rop, rlen));
        end

        // Reset during the second write of a 4-word COPY.
        loadMem();
        @(negedge clk);
        cmd_op = 2'b00; cmd_src = 4'd0; cmd_dst = 4'd8; cmd_len = 5'd4; cmd_data = '0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wr = 0;
        for (int k = 0; k < 50 && wr < 2; k++) begin
            @(negedge clk);
            if (rf_we) wr++;
        end
        checkOutput("reached_second_write", 64'(wr), 64'd2);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {rf_re, rf_we, done, busy, xfer_cnt, rf_rAddr, rf_wAddr, rf_wData}, 64'd0);
        expMem[8] = expMem[0];
        wr = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rf_we || rf_re || done) wr++;
        end
        checkOutput("activity_in_reset", 64'(wr), 64'd0);
        reset_n = 1'b1;
        wr = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rf_we || rf_re || done || busy) wr++;
        end
        checkOutput("activity_after_abort", 64'(wr), 64'd0);
        checkOutput("cmd_ready_after_abort", 64'(cmd_ready), 64'd1);
        checkMem("mem_after_abort");

        // The DUT still works after the abort.
        applyStimulus(2'b10, 4'd8, 4'd12, 5'd2, 32'h10, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_dma_master.md
REGFILE_DMA_MASTER -- requirements
Module: regfile_dma_master

Interface
REQ-001 Parameter: DATA_W, 32, data width of register-file words and cmd_data.
REQ-002 Port: clk  in  1  clock; all state changes on the rising edge.
REQ-003 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: cmd_valid  in  1  command request.
REQ-005 Port: cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 Port: cmd_op  in  2  operation: 00 COPY, 01 FILL, 10 ADDK, 11 reserved.
REQ-007 Port: cmd_src  in  4  first source register index.
REQ-008 Port: cmd_dst  in  4  first destination register index.
REQ-009 Port: cmd_len  in  5  word count, 0..31.
REQ-010 Port: cmd_data  in  DATA_W  FILL value or ADDK addend.
REQ-011 Port: rf_re  out  1  register-file read enable.
REQ-012 Port: rf_rAddr  out  4  register-file read index.
REQ-013 Port: rf_rData  in  DATA_W  register-file read data, registered, valid the cycle after rf_re.
REQ-014 Port: rf_we  out  1  register-file write enable.
REQ-015 Port: rf_wAddr  out  4  register-file write index.
REQ-016 Port: rf_wData  out  DATA_W  register-file write data.
REQ-017 Port: busy  out  1  high in any state other than IDLE.
REQ-018 Port: done  out  1  one-cycle completion pulse.
REQ-019 Port: xfer_cnt  out  5  words written in the current or last command.

Function
REQ-020 FSM states SHALL be IDLE, RD, CAP, WR, DONE; all outputs registered or decoded from state and registers only.
REQ-021 cmd_ready SHALL be 1 only in IDLE; on acceptance, op/src/dst/len/data latched, xfer_cnt cleared to 0.
REQ-022 Acceptance with cmd_len=0 or cmd_op=11 SHALL go IDLE->DONE with no rf_re/rf_we pulse.
REQ-023 COPY/ADDK acceptance SHALL go IDLE->RD; FILL acceptance SHALL go IDLE->WR.
REQ-024 RD: rf_re=1, rf_rAddr=src_ptr, rf_we=0; next state CAP.
REQ-025 CAP: rf_re=0, rf_we=0; buf <= rf_rData (COPY) or rf_rData+data mod 2^DATA_W (ADDK); next state WR.
REQ-026 WR: rf_we=1, rf_wAddr=dst_ptr, rf_wData=buf (COPY/ADDK) or latched cmd_data (FILL), rf_re=0.
REQ-027 At WR exit: xfer_cnt+1, src_ptr+1 and dst_ptr+1 mod 16 (15 wraps to 0); if xfer_cnt+1==len next state DONE, else RD (COPY/ADDK) or WR (FILL).
REQ-028 rf_re and rf_we SHALL never be 1 in the same cycle.
REQ-029 Ordering: word i written before word i+1 read, so overlapping ranges give forward-copy semantics.
REQ-030 DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
REQ-031 Latency: COPY/ADDK of N words = 3N cycles RD/CAP/WR, done in cycle 3N+1 after acceptance edge; FILL done in cycle N+1; len 0 done in cycle 1.
REQ-032 cmd_valid or input changes while busy SHALL be ignored; no queueing.
REQ-033 When not in RD/WR, rf_rAddr, rf_wAddr, rf_wData SHALL hold their last values; rf_re=rf_we=0.

Reset
REQ-034 reset_n low SHALL immediately force IDLE; rf_re, rf_we, done, busy, xfer_cnt, rf_rAddr, rf_wAddr, rf_wData, buf all 0; cmd_ready 1 after release.
REQ-035 Reset mid-command SHALL abort it with no further regfile access and no done pulse.

Verification
REQ-036 COPY src=2 dst=8 len=3, R2..R4=0x11,0x22,0x33 -> R8..R10 equal them, done in cycle 10, xfer_cnt=3.
REQ-037 FILL dst=14 len=4 data=0xDEADBEEF -> R14,R15,R0,R1=0xDEADBEEF (wrap), done in cycle 5.
REQ-038 ADDK src=5 dst=5 len=1 data=0xFFFFFFFF, R5=0x00000001 -> R5=0x00000000, done in cycle 4.
REQ-039 COPY src=0 dst=1 len=3, R0=0xA, R1=0xB -> R1..R3=0xA (forward overlap).
REQ-040 len=0 and op=11 -> done in cycle 1, zero rf_re/rf_we pulses; cmd_valid during busy ignored.
REQ-041 reset_n low during second WR of len=4 COPY -> outputs 0 asynchronously, only 1 destination word written, no done.
